// File: rtl/exu_wbck_pkg.sv
// Shared widths and FSM encodings for the EXU writeback/commit stage.
package exu_wbck_pkg;

    localparam int WBCK_XLEN       = 32;
    localparam int WBCK_RFIDX_W    = 5;
    localparam int WBCK_OUTS_CNT_W = 2;
    localparam int WBCK_INSTRET_W  = 64;

    typedef enum logic [1:0] {
        WBCK_RUN    = 2'd0,
        WBCK_DRAIN  = 2'd1,
        WBCK_HALTED = 2'd2
    } wbck_state_e;

endpackage

// File: rtl/exu_wbck_if.sv
// Handshake and result bundle between ALU/LSU, the writeback stage and the regfile/commit side.
interface exu_wbck_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic               alu_wbck_i_valid;
    logic               alu_wbck_i_ready;
    logic [XLEN-1:0]    alu_wbck_i_wdat;
    logic [RFIDX_W-1:0] alu_wbck_i_rdidx;
    logic               alu_wbck_i_rdwen;
    logic               alu_cmt_i_ebreak;
    logic [XLEN-1:0]    alu_cmt_i_pc;

    logic               lsu_req_fire;
    logic               lsu_wbck_i_valid;
    logic               lsu_wbck_i_ready;
    logic [XLEN-1:0]    lsu_wbck_i_wdat;
    logic [RFIDX_W-1:0] lsu_wbck_i_rdidx;
    logic               lsu_wbck_i_rdwen;
    logic               lsu_outs_full;

    logic               rf_wbck_o_ena;
    logic [RFIDX_W-1:0] rf_wbck_o_idx;
    logic [XLEN-1:0]    rf_wbck_o_wdat;
    logic               cmt_o_halt;
    logic [XLEN-1:0]    cmt_o_halt_pc;
    logic [63:0]        cmt_o_instret;

    // Upstream/environment side.
    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_rdwen,
               alu_cmt_i_ebreak, alu_cmt_i_pc,
               lsu_req_fire, lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
               lsu_wbck_i_rdwen,
        input  alu_wbck_i_ready, lsu_wbck_i_ready, lsu_outs_full,
               rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat,
               cmt_o_halt, cmt_o_halt_pc, cmt_o_instret
    );

    // Writeback stage side.
    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_rdwen,
               alu_cmt_i_ebreak, alu_cmt_i_pc,
               lsu_req_fire, lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
               lsu_wbck_i_rdwen,
        output alu_wbck_i_ready, lsu_wbck_i_ready, lsu_outs_full,
               rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat,
               cmt_o_halt, cmt_o_halt_pc, cmt_o_instret
    );

endinterface

// File: rtl/exu_wbck_outs_cnt.sv
// Saturating up/down counter of LSU requests still waiting for their writeback.
module exu_wbck_outs_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full
);

    localparam logic [W-1:0] MAX = '1;

    // Simultaneous inc/dec cancel; overflow and underflow hold the value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full = (cnt == MAX);

endmodule

// File: rtl/exu_wbck.sv
// Writeback/commit stage: LSU-priority arbitration onto one registered regfile
// write port, outstanding-LSU tracking, ebreak halt FSM and instret counter.
module exu_wbck
    import exu_wbck_pkg::*;
#(
    parameter int XLEN       = WBCK_XLEN,
    parameter int RFIDX_W    = WBCK_RFIDX_W,
    parameter int OUTS_CNT_W = WBCK_OUTS_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    exu_wbck_if.slave  wb
);

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
    } wbck_req_t;

    wbck_state_e              state;
    logic [OUTS_CNT_W-1:0]    outs_cnt;
    logic                     outs_full;

    logic                     alu_ready, lsu_ready;
    logic                     alu_xfer, lsu_xfer, any_xfer, alu_ebrk;
    wbck_req_t                alu_req, lsu_req, sel_req;
    logic                     sel_wen;

    logic                     rf_ena;
    logic [RFIDX_W-1:0]       rf_idx;
    logic [XLEN-1:0]          rf_wdat;
    logic                     halt;
    logic [XLEN-1:0]          halt_pc;
    logic [WBCK_INSTRET_W-1:0] instret;

    // Readys are held low while reset is asserted so nothing looks accepted.
    assign lsu_ready = rst_n & (state != WBCK_HALTED);
    assign alu_ready = rst_n & (state == WBCK_RUN) & ~wb.lsu_wbck_i_valid;

    assign alu_xfer = wb.alu_wbck_i_valid & alu_ready;
    assign lsu_xfer = wb.lsu_wbck_i_valid & lsu_ready;
    assign any_xfer = alu_xfer | lsu_xfer;
    assign alu_ebrk = alu_xfer & wb.alu_cmt_i_ebreak;

    assign alu_req = '{wdat: wb.alu_wbck_i_wdat, rdidx: wb.alu_wbck_i_rdidx,
                       rdwen: wb.alu_wbck_i_rdwen};
    assign lsu_req = '{wdat: wb.lsu_wbck_i_wdat, rdidx: wb.lsu_wbck_i_rdidx,
                       rdwen: wb.lsu_wbck_i_rdwen};
    assign sel_req = lsu_xfer ? lsu_req : alu_req;
    // x0 is hardwired and ebreak retires without a register result.
    assign sel_wen = sel_req.rdwen & (sel_req.rdidx != '0) & ~alu_ebrk;

    exu_wbck_outs_cnt #(.W(OUTS_CNT_W)) u_outs_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb.lsu_req_fire),
        .dec   (lsu_xfer),
        .cnt   (outs_cnt),
        .full  (outs_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WBCK_RUN;
            rf_ena  <= 1'b0;
            rf_idx  <= '0;
            rf_wdat <= '0;
            halt    <= 1'b0;
            halt_pc <= '0;
            instret <= '0;
        end else begin
            rf_ena <= any_xfer & sel_wen;
            if (any_xfer) begin
                rf_idx  <= sel_req.rdidx;
                rf_wdat <= sel_req.wdat;
                instret <= instret + 64'd1;
            end
            case (state)
                WBCK_RUN: begin
                    if (alu_ebrk) begin
                        halt_pc <= wb.alu_cmt_i_pc;
                        if (outs_cnt == '0 ||
                            (outs_cnt == OUTS_CNT_W'(1) && lsu_xfer)) begin
                            state <= WBCK_HALTED;
                            halt  <= 1'b1;
                        end else begin
                            state <= WBCK_DRAIN;
                        end
                    end
                end
                WBCK_DRAIN: begin
                    if (outs_cnt == '0) begin
                        state <= WBCK_HALTED;
                        halt  <= 1'b1;
                    end
                end
                WBCK_HALTED: ;
                default: state <= WBCK_RUN;
            endcase
        end
    end

    assign wb.alu_wbck_i_ready = alu_ready;
    assign wb.lsu_wbck_i_ready = lsu_ready;
    assign wb.lsu_outs_full    = outs_full;
    assign wb.rf_wbck_o_ena    = rf_ena;
    assign wb.rf_wbck_o_idx    = rf_idx;
    assign wb.rf_wbck_o_wdat   = rf_wdat;
    assign wb.cmt_o_halt       = halt;
    assign wb.cmt_o_halt_pc    = halt_pc;
    assign wb.cmt_o_instret    = instret;

endmodule

// File: tb/tb_exu_wbck.sv
// Scoreboard bench for exu_wbck: directed vectors push expected regfile writes, a monitor pops them.
module tb_exu_wbck;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_wbck_if #(.XLEN(32), .RFIDX_W(5)) bus ();

    exu_wbck #(.XLEN(32), .RFIDX_W(5), .OUTS_CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] wdat;
    } exp_t;

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    longint unsigned exp_instret = 0;
    int              m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rf_wbck_o_ena === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rf_write_unexpected: got idx=%0d wdat=0x%0h, expected no write",
                         bus.rf_wbck_o_idx, bus.rf_wbck_o_wdat);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_wbck_o_idx !== e.idx || bus.rf_wbck_o_wdat !== e.wdat) begin
                    n_err++;
                    $display("FAIL rf_write: got idx=%0d wdat=0x%0h, expected idx=%0d wdat=0x%0h",
                             bus.rf_wbck_o_idx, bus.rf_wbck_o_wdat, e.idx, e.wdat);
                end
            end
        end
    end

    // Protocol model of the outstanding count: catches overflow/underflow by the stimulus.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt <= 0;
        end else begin
            assert (!(bus.lsu_wbck_i_valid && m_cnt == 0))
                else $error("LSU completion with nothing outstanding");
            assert (!(bus.lsu_req_fire && m_cnt == 3 &&
                      !(bus.lsu_wbck_i_valid && bus.lsu_wbck_i_ready)))
                else $error("LSU request issued while outstanding count is full");
            m_cnt <= m_cnt + (bus.lsu_req_fire ? 1 : 0)
                           - ((bus.lsu_wbck_i_valid && bus.lsu_wbck_i_ready) ? 1 : 0);
        end
    end

    task automatic alu_send(input logic [4:0] idx, input logic [31:0] d, input logic wen,
                            input logic ebrk, input logic [31:0] pc);
        bit done = 1'b0;
        @(posedge clk); #1;
        bus.alu_wbck_i_rdidx = idx;
        bus.alu_wbck_i_wdat  = d;
        bus.alu_wbck_i_rdwen = wen;
        bus.alu_cmt_i_ebreak = ebrk;
        bus.alu_cmt_i_pc     = pc;
        bus.alu_wbck_i_valid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (bus.alu_wbck_i_ready === 1'b1) begin
                if (wen && idx != 5'd0 && !ebrk) exp_q.push_back('{idx, d});
                exp_instret++;
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        bus.alu_wbck_i_valid = 1'b0;
        bus.alu_cmt_i_ebreak = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL alu_handshake: got no ready within 16 cycles, expected ready");
        end
    endtask

    task automatic lsu_send(input logic [4:0] idx, input logic [31:0] d, input logic wen,
                            input logic fire);
        bit done = 1'b0;
        @(posedge clk); #1;
        bus.lsu_wbck_i_rdidx = idx;
        bus.lsu_wbck_i_wdat  = d;
        bus.lsu_wbck_i_rdwen = wen;
        bus.lsu_req_fire     = fire;
        bus.lsu_wbck_i_valid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (bus.lsu_wbck_i_ready === 1'b1) begin
                if (wen && idx != 5'd0) exp_q.push_back('{idx, d});
                exp_instret++;
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        bus.lsu_wbck_i_valid = 1'b0;
        bus.lsu_req_fire     = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL lsu_handshake: got no ready within 16 cycles, expected ready");
        end
    endtask

    task automatic fire_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.lsu_req_fire = 1'b1;
            @(posedge clk); #1;
            bus.lsu_req_fire = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_instret = 0;
    endtask

    initial begin
        bit seen;
        bus.alu_wbck_i_valid = 1'b1;
        bus.alu_wbck_i_wdat  = 32'h11;
        bus.alu_wbck_i_rdidx = 5'd1;
        bus.alu_wbck_i_rdwen = 1'b1;
        bus.alu_cmt_i_ebreak = 1'b0;
        bus.alu_cmt_i_pc     = 32'h0;
        bus.lsu_req_fire     = 1'b0;
        bus.lsu_wbck_i_valid = 1'b1;
        bus.lsu_wbck_i_wdat  = 32'h22;
        bus.lsu_wbck_i_rdidx = 5'd2;
        bus.lsu_wbck_i_rdwen = 1'b1;

        // Reset held with both sources valid: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_alu_ready", bus.alu_wbck_i_ready, 0);
            check("rst_lsu_ready", bus.lsu_wbck_i_ready, 0);
        end
        check("rst_rf_ena", bus.rf_wbck_o_ena, 0);
        check("rst_rf_idx", bus.rf_wbck_o_idx, 0);
        check("rst_rf_wdat", bus.rf_wbck_o_wdat, 0);
        check("rst_halt", bus.cmt_o_halt, 0);
        check("rst_halt_pc", bus.cmt_o_halt_pc, 0);
        check("rst_instret", bus.cmt_o_instret, 0);
        check("rst_full", bus.lsu_outs_full, 0);
        @(posedge clk); #1;
        bus.alu_wbck_i_valid = 1'b0;
        bus.lsu_wbck_i_valid = 1'b0;
        rst_n = 1'b1;

        // Plain ALU writes, x0 and rdwen=0 suppress the write but still retire.
        alu_send(5'd5, 32'h1234, 1'b1, 1'b0, 32'h0);
        @(negedge clk); check("alu_instret_1", bus.cmt_o_instret, exp_instret);
        alu_send(5'd0, 32'hDEAD, 1'b1, 1'b0, 32'h0);
        @(negedge clk); check("alu_x0_instret", bus.cmt_o_instret, exp_instret);
        alu_send(5'd6, 32'h0077, 1'b0, 1'b0, 32'h0);
        @(negedge clk); check("alu_nowen_instret", bus.cmt_o_instret, exp_instret);

        // LSU and ALU valid together: LSU goes first.
        fire_pulse(1);
        @(posedge clk); #1;
        bus.lsu_wbck_i_rdidx = 5'd3; bus.lsu_wbck_i_wdat = 32'hAAAA; bus.lsu_wbck_i_rdwen = 1'b1;
        bus.alu_wbck_i_rdidx = 5'd4; bus.alu_wbck_i_wdat = 32'hBBBB; bus.alu_wbck_i_rdwen = 1'b1;
        bus.lsu_wbck_i_valid = 1'b1; bus.alu_wbck_i_valid = 1'b1;
        @(negedge clk);
        check("arb_alu_blocked", bus.alu_wbck_i_ready, 0);
        check("arb_lsu_ready", bus.lsu_wbck_i_ready, 1);
        exp_q.push_back('{5'd3, 32'hAAAA}); exp_instret++;
        @(posedge clk); #1;
        bus.lsu_wbck_i_valid = 1'b0;
        @(negedge clk);
        check("arb_alu_ready_after", bus.alu_wbck_i_ready, 1);
        exp_q.push_back('{5'd4, 32'hBBBB}); exp_instret++;
        @(posedge clk); #1;
        bus.alu_wbck_i_valid = 1'b0;
        @(negedge clk); check("arb_instret", bus.cmt_o_instret, exp_instret);

        // Fill the outstanding counter, then fire + complete in the same cycle.
        fire_pulse(3);
        @(negedge clk); check("outs_full_at_3", bus.lsu_outs_full, 1);
        lsu_send(5'd9, 32'h9999, 1'b1, 1'b1);
        @(negedge clk); check("outs_full_fire_and_done", bus.lsu_outs_full, 1);
        lsu_send(5'd10, 32'h1010, 1'b1, 1'b0);
        @(negedge clk); check("outs_not_full_at_2", bus.lsu_outs_full, 0);

        // Ebreak with two loads outstanding drains before halting.
        alu_send(5'd1, 32'hE, 1'b1, 1'b1, 32'h8000_0020);
        @(negedge clk);
        check("drain_alu_blocked", bus.alu_wbck_i_ready, 0);
        check("drain_no_halt", bus.cmt_o_halt, 0);
        check("drain_halt_pc", bus.cmt_o_halt_pc, 32'h8000_0020);
        lsu_send(5'd7, 32'h7777, 1'b1, 1'b0);
        @(negedge clk);
        check("drain_no_halt_after_first", bus.cmt_o_halt, 0);
        check("drain_alu_blocked_2", bus.alu_wbck_i_ready, 0);
        lsu_send(5'd8, 32'h8888, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.cmt_o_halt === 1'b1) seen = 1'b1;
        end
        check("drain_halt_rises", bus.cmt_o_halt, 1);
        check("drain_halted_pc", bus.cmt_o_halt_pc, 32'h8000_0020);
        check("drain_instret", bus.cmt_o_instret, exp_instret);
        check("halted_alu_ready", bus.alu_wbck_i_ready, 0);
        check("halted_lsu_ready", bus.lsu_wbck_i_ready, 0);

        pulse_reset(2);
        @(negedge clk);
        check("rst2_halt", bus.cmt_o_halt, 0);
        check("rst2_instret", bus.cmt_o_instret, 0);
        check("rst2_alu_ready", bus.alu_wbck_i_ready, 1);

        // Reset in DRAIN returns to RUN with an empty counter.
        fire_pulse(2);
        alu_send(5'd1, 32'h0, 1'b0, 1'b1, 32'h8000_0030);
        @(negedge clk); check("drain_b_alu_blocked", bus.alu_wbck_i_ready, 0);
        pulse_reset(1);
        @(negedge clk);
        check("rst3_halt", bus.cmt_o_halt, 0);
        check("rst3_halt_pc", bus.cmt_o_halt_pc, 0);
        check("rst3_alu_ready", bus.alu_wbck_i_ready, 1);
        check("rst3_full", bus.lsu_outs_full, 0);
        fire_pulse(2);
        @(negedge clk); check("rst3_cnt_2_not_full", bus.lsu_outs_full, 0);
        fire_pulse(1);
        @(negedge clk); check("rst3_cnt_3_full", bus.lsu_outs_full, 1);
        lsu_send(5'd11, 32'hB0B0, 1'b1, 1'b0);
        lsu_send(5'd12, 32'hC0C0, 1'b1, 1'b0);
        lsu_send(5'd13, 32'hD0D0, 1'b1, 1'b0);

        // Ebreak with nothing outstanding halts immediately.
        alu_send(5'd2, 32'h22, 1'b1, 1'b1, 32'h8000_0010);
        @(negedge clk);
        check("halt_now", bus.cmt_o_halt, 1);
        check("halt_now_pc", bus.cmt_o_halt_pc, 32'h8000_0010);
        check("halt_now_instret", bus.cmt_o_instret, exp_instret);
        @(posedge clk); #1;
        bus.alu_wbck_i_rdidx = 5'd15; bus.alu_wbck_i_wdat = 32'hF00D; bus.alu_wbck_i_rdwen = 1'b1;
        bus.alu_wbck_i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halted_alu_stays_blocked", bus.alu_wbck_i_ready, 0);
            check("halted_lsu_stays_blocked", bus.lsu_wbck_i_ready, 0);
        end
        @(posedge clk); #1;
        bus.alu_wbck_i_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("expected_writes_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exu_wbck.md
Name: exu_wbck

Overview:
- Writeback/commit stage directly downstream of the ALU regular path.
- Consumes the ALU result handshake (valid/ready, write data, ebreak flag) and the LSU long-pipe writeback.
- Arbitrates the two sources onto a single registered regfile write port.
- Tracks outstanding LSU requests, runs the ebreak halt state machine and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; matches the XLEN define.
- RFIDX_W, 5, regfile index width.
- OUTS_CNT_W, 2, width of the outstanding-LSU counter; maximum outstanding = 2^OUTS_CNT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_wbck_i_valid  in  1  ALU result valid
- alu_wbck_i_ready  out  1  ALU result accepted
- alu_wbck_i_wdat  in  XLEN  ALU result data
- alu_wbck_i_rdidx  in  RFIDX_W  destination register
- alu_wbck_i_rdwen  in  1  destination write enable
- alu_cmt_i_ebreak  in  1  instruction is ebreak
- alu_cmt_i_pc  in  XLEN  PC of the ALU instruction
- lsu_req_fire  in  1  LSU request issued this cycle
- lsu_wbck_i_valid  in  1  LSU load/store completion valid
- lsu_wbck_i_ready  out  1  LSU completion accepted
- lsu_wbck_i_wdat  in  XLEN  load data
- lsu_wbck_i_rdidx  in  RFIDX_W  load destination
- lsu_wbck_i_rdwen  in  1  write enable (0 for stores)
- rf_wbck_o_ena  out  1  regfile write strobe
- rf_wbck_o_idx  out  RFIDX_W  regfile write index
- rf_wbck_o_wdat  out  XLEN  regfile write data
- cmt_o_halt  out  1  core halted by ebreak (sticky)
- cmt_o_halt_pc  out  XLEN  PC of the halting ebreak
- cmt_o_instret  out  64  retired-instruction count
- lsu_outs_full  out  1  outstanding counter at maximum; upstream must not issue

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; FSM=RUN; outstanding counter=0; instret=0. Reset applied mid-operation discards any registered write and any pending halt.
- Handshake: a transfer occurs when valid&ready are both high at a clk edge. Valid, once high, must stay high with stable data until ready is seen.
- Arbitration, LSU priority for in-order long-pipe completion:
  - lsu_wbck_i_ready = (state!=HALTED).
  - alu_wbck_i_ready = (state==RUN) & ~lsu_wbck_i_valid.
  - ALU is therefore blocked in any cycle where the LSU is valid.
- Writeback latency is one cycle. The accepted source's rdidx/wdat are registered into rf_wbck_o_*. rf_wbck_o_ena=rdwen & (rdidx!=0) & ~ebreak, high for exactly one cycle; ena=0 in cycles with no transfer.
- Outstanding counter:
  - +1 on lsu_req_fire; -1 on an LSU transfer; unchanged when both occur in the same cycle.
  - lsu_outs_full=(cnt==max).
  - Overflow (fire at max) and underflow (LSU valid at 0) are protocol errors, flagged by bench assertions. RTL saturates in both cases.
- Instret: +1 per ALU transfer (ebreak included) and per LSU transfer. Wraps modulo 2^64.
- FSM:
  - RUN: an ALU transfer with ebreak=1 latches halt_pc. If cnt==0, or cnt==1 with an LSU transfer in the same cycle, go to HALTED; otherwise go to DRAIN.
  - DRAIN: ALU is blocked; LSU transfers continue. Go to HALTED in the cycle after cnt reaches 0.
  - HALTED: cmt_o_halt=1, both readys=0, no regfile writes. Exited only by reset.
- Ebreak writes nothing to the regfile.
- cmt_o_halt is asserted the cycle after entering HALTED is decided, i.e. registered.

Decomposition:
- Shared defines header: XLEN, RFIDX width, and FSM state encodings (WBCK_RUN=2'd0, WBCK_DRAIN=2'd1, WBCK_HALTED=2'd2).
- One natural sub-module: wbck_outs_cnt, the saturating up/down outstanding counter with its full flag.
- Arbitration, the writeback register and the FSM remain in exu_wbck.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high -> readys=0 during reset, all outputs 0, instret=0; after release, first ALU transfer gives rf_wbck_o_ena=1 one cycle later.
- ALU write of rdidx=5, wdat=0x1234, rdwen=1 -> next cycle ena=1, idx=5, wdat=0x1234, instret=1. Same with rdidx=0 -> ena=0, instret=2.
- Simultaneous LSU (rdidx=3, 0xAAAA) and ALU (rdidx=4, 0xBBBB) valid -> LSU written first; alu ready=0 that cycle. ALU write of 4 lands one cycle later.
- Ebreak at pc=0x80000010 with cnt=0 -> no regfile write, cmt_o_halt=1, halt_pc=0x80000010, both readys stay 0 thereafter.
- Ebreak with cnt=2 -> DRAIN. Two LSU completions (rdidx 7 and 8) both written; halt rises only after the second; ALU ready=0 throughout.
- Outstanding: three lsu_req_fire pulses -> lsu_outs_full=1. Simultaneous fire plus LSU transfer -> cnt unchanged, full stays 1. Assert rst_n=0 in DRAIN -> returns to RUN with cnt=0 and halt=0.
